// File: rtl/jacaranda_pkg.sv
// Shared definitions for the jacaranda-8 core: opcodes, iret encoding,
// fetch FSM states and the default PC width.
package jacaranda_pkg;

    localparam int PC_W_DEF = 8;

    localparam logic [3:0] OP_MOV = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_AND = 4'b0011;
    localparam logic [3:0] OP_OR  = 4'b0100;
    localparam logic [3:0] OP_XOR = 4'b0101;
    localparam logic [3:0] OP_CMP = 4'b0110;
    localparam logic [3:0] OP_LDI = 4'b0111;
    localparam logic [3:0] OP_LD  = 4'b1000;
    localparam logic [3:0] OP_ST  = 4'b1001;
    localparam logic [3:0] OP_JE  = 4'b1010;
    localparam logic [3:0] OP_JMP = 4'b1011;

    // rd_a field value that turns a control-class opcode into iret
    localparam logic [1:0] RD_IRET = 2'b01;

    typedef enum logic [0:0] {
        ST_FETCH = 1'b0,
        ST_ISSUE = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch / PC stage: req/ack fetch from instruction memory, one-cycle
// issue to the decoder, next-PC selection and interrupt entry/return.
module fetch_unit
    import jacaranda_pkg::*;
#(
    parameter int              PC_W     = PC_W_DEF,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clock,
    input  logic            reset,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [7:0]      imem_rdata,
    output logic            instr_valid,
    output logic [3:0]      opcode,
    output logic [1:0]      rd_a,
    output logic [1:0]      rs_a,
    output logic [PC_W-1:0] pc,
    input  logic            jmp_en,
    input  logic            je_en,
    input  logic            ret,
    input  logic            flag,
    input  logic [7:0]      rs_data,
    input  logic            int_req,
    input  logic [PC_W-1:0] int_vec,
    output logic            int_ack,
    output logic            int_en
);

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] epc_q, epc_d;
    logic [7:0]      instr_q;
    logic            int_en_q, int_en_d;
    logic            take_int;
    logic [PC_W-1:0] seq_pc;

    // Return takes precedence over both jump kinds; jmp_en beats je_en.
    function automatic logic [PC_W-1:0] next_pc(
        input logic            f_ret,
        input logic            f_jmp,
        input logic            f_je,
        input logic            f_flag,
        input logic [PC_W-1:0] f_epc,
        input logic [PC_W-1:0] f_pc,
        input logic [7:0]      f_tgt
    );
        if (f_ret)
            return f_epc;
        else if (f_jmp || (f_je && f_flag))
            return PC_W'(f_tgt);
        else
            return f_pc + 1'b1;
    endfunction

    always_ff @(posedge clock) begin
        if (reset)
            state_q <= ST_FETCH;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH: if (imem_ack) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_FETCH;
            default:  state_d = ST_FETCH;
        endcase
    end

    // Strobes are gated by reset so nothing leaks out during the reset cycle.
    always_comb begin
        imem_req    = !reset && (state_q == ST_FETCH);
        instr_valid = !reset && (state_q == ST_ISSUE);
        int_ack     = instr_valid && take_int;
    end

    assign take_int = int_req && int_en_q && !ret;
    assign seq_pc   = next_pc(ret, jmp_en, je_en, flag, epc_q, pc_q, rs_data);

    always_comb begin
        pc_d     = pc_q;
        epc_d    = epc_q;
        int_en_d = int_en_q;
        if (state_q == ST_ISSUE) begin
            pc_d = seq_pc;
            if (ret)
                int_en_d = 1'b1;
            if (take_int) begin
                epc_d    = seq_pc;
                pc_d     = int_vec;
                int_en_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            epc_q    <= '0;
            instr_q  <= 8'h00;
            int_en_q <= 1'b1;
        end else begin
            pc_q     <= pc_d;
            epc_q    <= epc_d;
            int_en_q <= int_en_d;
            if (state_q == ST_FETCH && imem_ack)
                instr_q <= imem_rdata;
        end
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign opcode    = instr_q[7:4];
    assign rd_a      = instr_q[3:2];
    assign rs_a      = instr_q[1:0];
    assign int_en    = int_en_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized and directed bench for fetch_unit against an instruction-level
// reference model of PC, epc and interrupt-enable behaviour.
module tb_fetch_unit;

    logic       clock = 1'b0;
    logic       reset;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack;
    logic [7:0] imem_rdata;
    logic       instr_valid;
    logic [3:0] opcode;
    logic [1:0] rd_a;
    logic [1:0] rs_a;
    logic [7:0] pc;
    logic       jmp_en, je_en, ret, flag;
    logic [7:0] rs_data;
    logic       int_req;
    logic [7:0] int_vec;
    logic       int_ack;
    logic       int_en;

    int checks   = 0;
    int failures = 0;

    logic [7:0] m_pc, m_epc, m_instr;
    logic       m_inten;

    always #5 clock = ~clock;

    fetch_unit #(.PC_W(8), .RESET_PC(8'h00)) dut (
        .clock      (clock),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .instr_valid(instr_valid),
        .opcode     (opcode),
        .rd_a       (rd_a),
        .rs_a       (rs_a),
        .pc         (pc),
        .jmp_en     (jmp_en),
        .je_en      (je_en),
        .ret        (ret),
        .flag       (flag),
        .rs_data    (rs_data),
        .int_req    (int_req),
        .int_vec    (int_vec),
        .int_ack    (int_ack),
        .int_en     (int_en)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc    = 8'h00;
        m_epc   = 8'h00;
        m_instr = 8'h00;
        m_inten = 1'b1;
    endtask

    // Reset held for two cycles with a stray ack present to prove it is ignored.
    task automatic apply_reset(input logic [7:0] stray);
        repeat (2) begin
            @(negedge clock);
            reset      = 1'b1;
            imem_ack   = 1'b1;
            imem_rdata = stray;
            int_req    = 1'b1;
            #1;
            check_eq("rst_req", imem_req, 0);
            check_eq("rst_valid", instr_valid, 0);
            check_eq("rst_intack", int_ack, 0);
        end
        @(negedge clock);
        reset    = 1'b0;
        imem_ack = 1'b0;
        int_req  = 1'b0;
        model_reset();
        $display("reset done pc=%02h", m_pc);
    endtask

    // One FETCH cycle; decoder-side inputs are scrambled since they must be ignored.
    task automatic fetch_cycle(input logic ack, input logic [7:0] data);
        if (clock) @(negedge clock);
        imem_ack   = ack;
        imem_rdata = data;
        jmp_en     = 1'($urandom);
        je_en      = 1'($urandom);
        ret        = 1'($urandom);
        flag       = 1'($urandom);
        rs_data    = 8'($urandom);
        int_req    = 1'($urandom);
        int_vec    = 8'($urandom);
        #1;
        check_eq("f_req", imem_req, 1);
        check_eq("f_addr", imem_addr, m_pc);
        check_eq("f_pc", pc, m_pc);
        check_eq("f_valid", instr_valid, 0);
        check_eq("f_intack", int_ack, 0);
        check_eq("f_opcode", opcode, m_instr[7:4]);
        check_eq("f_inten", int_en, m_inten);
        if (ack) m_instr = data;
        @(negedge clock);
    endtask

    task automatic issue_cycle(input logic j, input logic je, input logic f, input logic r,
                               input logic [7:0] tgt, input logic ir, input logic [7:0] vec);
        logic [7:0] np;
        logic       take;
        imem_ack   = 1'($urandom);
        imem_rdata = 8'($urandom);
        jmp_en     = j;
        je_en      = je;
        flag       = f;
        ret        = r;
        rs_data    = tgt;
        int_req    = ir;
        int_vec    = vec;
        #1;
        take = ir && m_inten && !r;
        check_eq("i_valid", instr_valid, 1);
        check_eq("i_req", imem_req, 0);
        check_eq("i_pc", pc, m_pc);
        check_eq("i_opcode", opcode, m_instr[7:4]);
        check_eq("i_rd", rd_a, m_instr[3:2]);
        check_eq("i_rs", rs_a, m_instr[1:0]);
        check_eq("i_inten", int_en, m_inten);
        check_eq("i_intack", int_ack, take);
        if (r)                np = m_epc;
        else if (j || (je && f)) np = tgt;
        else                  np = m_pc + 8'd1;
        if (r) m_inten = 1'b1;
        $display("issue pc=%02h instr=%02h j=%0b je=%0b f=%0b r=%0b ir=%0b take=%0b next=%02h",
                 m_pc, m_instr, j, je, f, r, ir, take, take ? vec : np);
        if (take) begin
            m_epc   = np;
            m_pc    = vec;
            m_inten = 1'b0;
        end else begin
            m_pc = np;
        end
        @(negedge clock);
    endtask

    task automatic run_instr(input int lat, input logic [7:0] data,
                             input logic j, input logic je, input logic f, input logic r,
                             input logic [7:0] tgt, input logic ir, input logic [7:0] vec);
        repeat (lat) fetch_cycle(1'b0, 8'($urandom));
        fetch_cycle(1'b1, data);
        issue_cycle(j, je, f, r, tgt, ir, vec);
    endtask

    initial begin
        reset = 1'b1; imem_ack = 1'b0; imem_rdata = 8'h00;
        jmp_en = 1'b0; je_en = 1'b0; ret = 1'b0; flag = 1'b0;
        rs_data = 8'h00; int_req = 1'b0; int_vec = 8'h00;
        model_reset();
        apply_reset(8'hA5);

        // Sequential sweep through the whole address space and the FF->00 wrap
        for (int i = 0; i < 257; i++)
            run_instr(0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 8'h00);
        check_eq("wrap_pc", m_pc, 8'h01);

        run_instr(0, 8'hB3, 1, 0, 0, 0, 8'h05, 0, 8'h00);   // -> 05
        run_instr(3, 8'h3C, 0, 0, 0, 0, 8'h00, 0, 8'h00);   // slow ack at 05 -> 06
        run_instr(0, 8'hB0, 1, 0, 0, 0, 8'h10, 0, 8'h00);   // -> 10
        run_instr(0, 8'hA1, 0, 1, 0, 0, 8'h40, 0, 8'h00);   // not taken -> 11
        run_instr(0, 8'hA1, 0, 1, 1, 0, 8'h40, 0, 8'h00);   // taken -> 40
        run_instr(0, 8'hB2, 1, 0, 0, 0, 8'h80, 0, 8'h00);   // -> 80
        run_instr(0, 8'hB2, 1, 1, 0, 0, 8'h20, 0, 8'h00);   // both, jmp wins -> 20
        run_instr(0, 8'h12, 0, 0, 0, 0, 8'h00, 1, 8'hF0);   // irq: epc=21 -> F0
        run_instr(0, 8'h34, 0, 0, 0, 0, 8'h00, 1, 8'hF0);   // masked -> F1
        run_instr(1, 8'hC4, 0, 0, 0, 1, 8'h00, 0, 8'h00);   // iret -> 21
        check_eq("iret_pc", m_pc, 8'h21);
        run_instr(0, 8'h12, 0, 0, 0, 0, 8'h00, 1, 8'hF0);   // irq: epc=22 -> F0
        run_instr(0, 8'hC4, 0, 0, 0, 1, 8'h00, 1, 8'hF0);   // iret beats irq -> 22
        run_instr(0, 8'h55, 0, 0, 0, 0, 8'h00, 1, 8'hF0);   // irq: epc=23 -> F0
        run_instr(0, 8'hC4, 0, 0, 0, 1, 8'h00, 0, 8'h00);   // iret -> 23
        check_eq("epc_ret_pc", m_pc, 8'h23);

        // Reset in the middle of a fetch that gets a late ack
        fetch_cycle(1'b0, 8'h00);
        apply_reset(8'h7E);
        run_instr(0, 8'h9A, 0, 0, 0, 0, 8'h00, 0, 8'h00);

        for (int i = 0; i < 400; i++) begin
            run_instr(int'($urandom_range(0, 3)), 8'($urandom),
                      ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
                      1'($urandom), ($urandom_range(0, 5) == 0),
                      8'($urandom), ($urandom_range(0, 3) == 0), 8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch and program-counter stage of the jacaranda-8 core. It sits directly upstream of the opcode decoder and fetches 8-bit instructions from instruction memory over a req/ack handshake. It presents opcode/rd_a/rs_a for one issue cycle and consumes the decoder's jmp_en/je_en/ret outputs in that same cycle to compute the next PC. It also owns interrupt entry: the saved return PC (epc) and the interrupt-enable bit.

Parameters:
PC_W, 8, width of PC, epc and instruction address
RESET_PC, 8'h00, PC value loaded on reset

Ports:
clock  input  1  core clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
imem_req  output  1  fetch request to instruction memory
imem_addr  output  PC_W  fetch address; equals pc
imem_ack  input  1  memory response; imem_rdata valid this cycle
imem_rdata  input  8  fetched instruction
instr_valid  output  1  high for exactly one cycle per issued instruction (ISSUE state)
opcode  output  4  instr[7:4] of the latched instruction
rd_a  output  2  instr[3:2]
rs_a  output  2  instr[1:0]
pc  output  PC_W  address of the current instruction
jmp_en  input  1  decoder: unconditional jump, target = rs_data
je_en  input  1  decoder: jump if flag set, target = rs_data
ret  input  1  decoder: iret
flag  input  1  compare-equal flag from the flag register
rs_data  input  8  register-file read of rs, the jump target
int_req  input  1  level interrupt request
int_vec  input  PC_W  interrupt handler address
int_ack  output  1  one-cycle pulse when an interrupt is taken
int_en  output  1  interrupt enable state

Behaviour:
- Reset values: state=FETCH, pc=RESET_PC, instr=8'h00, epc=0, int_en=1, imem_req=0, instr_valid=0, int_ack=0.
- In the reset cycle imem_req is 0. Any imem_ack during reset is ignored.
- States: FETCH, ISSUE.
- FETCH: imem_req=1 and imem_addr=pc, held stable until ack.
  - On imem_ack: instr<=imem_rdata; next state ISSUE.
  - imem_ack is ignored while imem_req=0.
  - Minimum latency is 1 cycle (ack in the first FETCH cycle), so best-case throughput is 1 instruction per 2 cycles.
- ISSUE: instr_valid=1, imem_req=0. opcode/rd_a/rs_a come from the instr register and stay stable through ISSUE and the following FETCH.
- Next PC is computed in ISSUE, priority high to low:
  1. ret: pc<=epc; int_en<=1.
  2. jmp_en: pc<=rs_data.
  3. je_en & flag: pc<=rs_data.
  4. Otherwise: pc<=pc+1, modulo 2^PC_W (8'hFF wraps to 8'h00).
- Interrupt entry, evaluated in ISSUE:
  - Condition: int_req & int_en & ~ret.
  - Action: epc<=the next PC computed above; pc<=int_vec; int_en<=0; int_ack=1 for this cycle.
  - An iret never takes an interrupt in the same cycle. A pending request is taken at the following ISSUE.
  - No nesting: int_en stays 0 until iret. An iret with int_en already 1 still restores epc.
- ISSUE always returns to FETCH.
- Decoder inputs (jmp_en, je_en, ret) are sampled only in ISSUE and ignored in FETCH.
- Simultaneous jmp_en and je_en: jmp_en wins; the target is identical anyway.
- Outputs are registered, except instr_valid, int_ack and imem_req, which are decoded from state.

Decomposition:
- Shared package jacaranda_pkg: opcode constants (OP_MOV..OP_ST, OP_JE=4'b1010, OP_JMP=4'b1011), rd_a code for iret (2'b01), fetch state enum, PC_W default.
- No sub-module needed. The next-PC select may be a local function.

Test Plan:
- Reset, then memory acks in 1 cycle with 8'h00 at every address -> imem_addr sequence 00,01,02,...,FF,00. instr_valid pulses every 2nd cycle; the wrap at FF is correct.
- Memory delays ack 3 cycles at pc=05 -> imem_req held 4 cycles with imem_addr=05 stable. Exactly one instr_valid follows; the PC does not advance early.
- ISSUE with je_en=1, flag=0, rs_data=8'h40 at pc=10 -> next fetch at 11. Repeat with flag=1 -> next fetch at 40. jmp_en=1, rs_data=8'h80 -> next fetch at 80.
- int_req=1 during ISSUE at pc=20 (sequential), int_vec=8'hF0 -> int_ack pulse, next fetch F0, epc=21, int_en=0. A second int_req is ignored until iret. iret (ret=1) -> next fetch 21, int_en=1.
- int_req held high while ISSUE has ret=1 -> no int_ack that cycle, fetch epc. int_ack fires at the next ISSUE with epc=(epc+1).
- Reset asserted mid-FETCH with a late imem_ack in the same cycle -> pc=RESET_PC, instr unchanged at 00, no instr_valid. Fetch restarts at RESET_PC.
